// File: rtl/pair_sum_accumulator_pkg.sv
// Shared definitions for the pair-sum accumulator: FSM encoding and default sizing.
package pair_sum_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int ACC_W_DEF = 8;
  localparam int COUNT_DEF = 4;
  // Wide enough for the largest legal COUNT (15).
  localparam int CNT_W     = 4;

endpackage

// File: rtl/pair_sum_accumulator_if.sv
// Operand-in / result-out handshake bundle for the pair-sum accumulator.
interface pair_sum_accumulator_if
  import pair_sum_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       a;
  logic [3:0]       b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, acc_out, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, acc_out, ovf
  );

endinterface

// File: rtl/pair_sum_accumulator_adder4bit.sv
// Team 4-bit ripple-carry adder: purely combinational, carry out on its own port.
module adder4bit (
  output logic [3:0] sum,
  output logic       carry,
  input  logic [3:0] a,
  input  logic [3:0] b
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    carry = c[4];
  end

endmodule

// File: rtl/pair_sum_accumulator.sv
// Accumulates COUNT 5-bit pair sums from adder4bit into an ACC_W-bit total with
// a sticky overflow flag, framed by IDLE/ACC/DONE over valid/ready handshakes.
module pair_sum_accumulator
  import pair_sum_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int COUNT = COUNT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  pair_sum_accumulator_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [3:0]         pair_sum;
  logic               pair_carry;
  logic [ACC_W:0]     acc_sum;
  logic               xfer;

  adder4bit u_adder (
    .sum   (pair_sum),
    .carry (pair_carry),
    .a     (bus.a),
    .b     (bus.b)
  );

  assign xfer    = bus.in_valid && (state_q == ACC);
  // One extra bit on top of the accumulator catches the wrap for ovf.
  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'({pair_carry, pair_sum});

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ACC: begin
        // a/b only reach state on a transfer, so garbage between pairs is harmless.
        if (xfer) begin
          acc_d = acc_sum[ACC_W-1:0];
          ovf_d = ovf_q | acc_sum[ACC_W];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == DONE);
  assign bus.acc_out   = acc_q;
  assign bus.ovf       = ovf_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_pair_sum_accumulator.sv
// Scoreboard bench for pair_sum_accumulator: a default (COUNT=4) instance and a
// COUNT=15 instance for the overflow run.
module tb_pair_sum_accumulator;
  import pair_sum_accumulator_pkg::*;

  typedef struct packed {
    logic [7:0] acc;
    logic       ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start15 = 1'b0;
  logic busy, busy15;

  int checks = 0;
  int errors = 0;
  int exp_sum = 0;
  int exp15 = 0;
  res_t sb_q[$];
  res_t sb15_q[$];

  always #5 clk = ~clk;

  pair_sum_accumulator_if #(.ACC_W(8)) bus ();
  pair_sum_accumulator_if #(.ACC_W(8)) bus15 ();

  pair_sum_accumulator #(.ACC_W(8), .COUNT(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .bus   (bus)
  );

  pair_sum_accumulator #(.ACC_W(8), .COUNT(15)) u_dut15 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start15),
    .busy  (busy15),
    .bus   (bus15)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Result checking: whenever a result is presented it must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      chk("sb_pending", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        chk("acc_out", bus.acc_out, sb_q[0].acc);
        chk("ovf", bus.ovf, sb_q[0].ovf);
        chk("in_ready_done", bus.in_ready, 0);
        if (bus.out_ready) void'(sb_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus15.out_valid) begin
      chk("sb15_pending", int'(sb15_q.size() > 0), 1);
      if (sb15_q.size() > 0) begin
        chk("acc_out15", bus15.acc_out, sb15_q[0].acc);
        chk("ovf15", bus15.ovf, sb15_q[0].ovf);
        if (bus15.out_ready) void'(sb15_q.pop_front());
      end
    end
  end

  task automatic start_run();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_sum = 0;
    chk("start_acc_clr", bus.acc_out, 0);
    chk("start_ovf_clr", bus.ovf, 0);
    chk("start_busy", busy, 1);
    chk("start_in_ready", bus.in_ready, 1);
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input int gaps);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    chk("in_ready", bus.in_ready, 1);
    exp_sum += int'(a) + int'(b);
    step();
    bus.in_valid = 1'b0;
    bus.a = 'x;
    bus.b = 'x;
    chk("acc_run", bus.acc_out, exp_sum & 255);
    for (int i = 0; i < gaps; i++) begin
      step();
      chk("acc_gap_hold", bus.acc_out, exp_sum & 255);
      chk("gap_in_ready", bus.in_ready, 1);
    end
  endtask

  // Called right after the final transfer edge; optionally waves start around.
  task automatic end_run(input int hold, input bit strobe_start);
    res_t r;
    chk("out_valid_lat", bus.out_valid, 1);
    r.acc = exp_sum[7:0];
    r.ovf = (exp_sum > 255);
    sb_q.push_back(r);
    bus.out_ready = 1'b0;
    start = strobe_start;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_out_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    start = 1'b0;
    chk("hs_idle_busy", busy, 0);
    chk("hs_out_valid", bus.out_valid, 0);
    chk("hs_acc_hold", bus.acc_out, exp_sum & 255);
    if (strobe_start) begin
      step();
      chk("hs_start_ignored", busy, 0);
    end
  endtask

  task automatic basic_pairs();
    send(4'b0000, 4'b0000, 0);
    send(4'b0000, 4'b1111, 0);
    send(4'b0001, 4'b1111, 0);
    send(4'b1111, 4'b1111, 0);
  endtask

  initial begin
    res_t r;
    bus.in_valid = 1'b0;  bus.a = '0;  bus.b = '0;  bus.out_ready = 1'b0;
    bus15.in_valid = 1'b0; bus15.a = '0; bus15.b = '0; bus15.out_ready = 1'b0;
    step();
    chk("rst_acc", bus.acc_out, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_busy15", busy15, 0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", bus.in_ready, 0);

    // Basic run
    start_run();
    basic_pairs();
    end_run(0, 1'b0);

    // Gaps between pairs and output backpressure
    start_run();
    send(4'b0101, 4'b1010, 2);
    send(4'b0011, 4'b1100, 2);
    send(4'b1000, 4'b1011, 2);
    send(4'b0000, 4'b1111, 0);
    end_run(5, 1'b0);

    // Asynchronous reset in the middle of a run
    start_run();
    send(4'd1, 4'd2, 0);
    send(4'd3, 4'd4, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_acc", bus.acc_out, 0);
    chk("midrst_ovf", bus.ovf, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_busy", busy, 0);
    #2 rst_n = 1'b1;
    step();
    start_run();
    basic_pairs();
    end_run(0, 1'b0);

    // start ignored in ACC, in DONE and in the handshake cycle
    start_run();
    send(4'd2, 4'd3, 0);
    send(4'd4, 4'd5, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_acc_hold", bus.acc_out, exp_sum & 255);
    chk("ign_busy", busy, 1);
    chk("ign_in_ready", bus.in_ready, 1);
    send(4'd6, 4'd7, 0);
    send(4'd8, 4'd9, 0);
    end_run(2, 1'b1);

    // Back-to-back runs
    start_run();
    basic_pairs();
    end_run(0, 1'b0);
    start_run();
    for (int i = 0; i < 4; i++) send(4'd1, 4'd1, 0);
    end_run(0, 1'b0);

    // Overflow run on the COUNT=15 instance
    start15 = 1'b1;
    step();
    start15 = 1'b0;
    exp15 = 0;
    chk("ovf15_start_busy", busy15, 1);
    for (int i = 0; i < 15; i++) begin
      bus15.in_valid = 1'b1;
      bus15.a = 4'hF;
      bus15.b = 4'hF;
      exp15 += 30;
      step();
      chk("ovf15_run", bus15.ovf, int'(exp15 > 255));
    end
    bus15.in_valid = 1'b0;
    chk("ovf15_out_valid", bus15.out_valid, 1);
    r.acc = exp15[7:0];
    r.ovf = (exp15 > 255);
    sb15_q.push_back(r);
    bus15.out_ready = 1'b1;
    step();
    bus15.out_ready = 1'b0;
    chk("ovf15_idle", busy15, 0);
    repeat (3) step();
    chk("ovf15_sticky", bus15.ovf, 1);
    chk("ovf15_acc_hold", bus15.acc_out, exp15 & 255);
    start15 = 1'b1;
    step();
    start15 = 1'b0;
    chk("ovf15_clr", bus15.ovf, 0);
    chk("ovf15_acc_clr", bus15.acc_out, 0);

    step();
    chk("sb_drained", sb_q.size() + sb15_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
